// File: rtl/alu_sched_pkg.sv
// Shared widths, instruction field offsets and FSM states for the ALU
// scheduler.
package alu_sched_pkg;
  localparam int OPC_W   = 3;
  localparam int DATA_W  = 8;
  localparam int INSTR_W = 19;
  localparam int OPC_LSB = 16;
  localparam int OP1_LSB = 8;
  localparam int OP2_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after the last
// granted requester, and the first asserted request wins.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);
  int   w_cand;
  logic w_found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = (int'(last_grant) + k) % NREQ;
      if (enable && !w_found && req[w_cand]) begin
        w_found        = 1'b1;
        grant[w_cand]  = 1'b1;
        grant_idx      = IDW'(w_cand);
      end
    end
  end
endmodule

// File: rtl/alu_sched.sv
// Time-shares one combinational ALU among NREQ requesters: arbitrate,
// execute for one cycle, then hold the result until the consumer takes it.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*INSTR_W-1:0] req_instr,
  output logic [DATA_W-1:0]       alu_operand1,
  output logic [DATA_W-1:0]       alu_operand2,
  output logic [7:0]              alu_select,
  input  logic [DATA_W-1:0]       alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [DATA_W-1:0]       rsp_result,
  output logic                    busy
);
  state_t               r_state;
  logic [INSTR_W-1:0]   r_instr;
  logic [IDW-1:0]       r_id;
  logic [IDW-1:0]       r_last_grant;
  logic [DATA_W-1:0]    r_result;

  logic [NREQ-1:0]      w_grant;
  logic [IDW-1:0]       w_grant_idx;
  logic [INSTR_W-1:0]   w_win_instr;
  logic                 w_exec;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .enable     (r_state == IDLE),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx)
  );

  assign w_win_instr = req_instr[INSTR_W*w_grant_idx +: INSTR_W];
  assign w_exec      = (r_state == EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_instr      <= '0;
      r_id         <= '0;
      r_last_grant <= IDW'(NREQ - 1);
      r_result     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_instr      <= w_win_instr;
            r_id         <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_state      <= EXEC;
          end
        end
        EXEC: begin
          r_result <= alu_result;
          r_state  <= RESP;
        end
        RESP: begin
          if (rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The ALU only sees a live operand/select pair while executing.
  assign alu_operand1 = w_exec ? r_instr[OP1_LSB +: DATA_W] : '0;
  assign alu_operand2 = w_exec ? r_instr[OP2_LSB +: DATA_W] : '0;
  assign alu_select   = w_exec ? (8'h01 << r_instr[OPC_LSB +: OPC_W]) : 8'h00;

  assign req_ready  = w_grant;
  assign rsp_valid  = (r_state == RESP);
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_alu_sched.sv
// Randomized and directed bench for alu_sched with a transaction-level
// reference model and an ALU stub (op1 + op2 + select index).
module tb_alu_sched;
  import alu_sched_pkg::*;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*INSTR_W-1:0] req_instr;
  logic [7:0]              alu_operand1, alu_operand2, alu_select, alu_result;
  logic                    rsp_valid, rsp_ready, busy;
  logic [IDW-1:0]          rsp_id;
  logic [7:0]              rsp_result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state
  int m_last = NREQ - 1;
  bit m_pend = 0;
  int m_age = 0;
  int m_id = 0, m_op1 = 0, m_op2 = 0, m_opc = 0;
  logic [NREQ-1:0] acc_flags = '0;

  int acc_id_q[$], acc_cyc_q[$], rsp_id_q[$], rsp_res_q[$], rsp_cyc_q[$], sel_q[$];

  int stub_idx;

  alu_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_instr(req_instr), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_select(alu_select), .alu_result(alu_result), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    stub_idx = 0;
    for (int k = 0; k < 8; k++) if (alu_select[k]) stub_idx = k;
    alu_result = (alu_select == 8'h00) ? 8'h00
               : 8'(int'(alu_operand1) + int'(alu_operand2) + stub_idx);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    int w, c;
    logic [INSTR_W-1:0] ins;
    acc_flags = '0;
    if (!rst_n) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_alu_select", alu_select, 0);
      m_pend = 0;
      m_last = NREQ - 1;
    end else if (!m_pend) begin
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_last + k) % NREQ;
        if (w < 0 && req_valid[c]) w = c;
      end
      chk("idle_req_ready", req_ready, (w < 0) ? 0 : (1 << w));
      chk("idle_busy", busy, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_alu_select", alu_select, 0);
      chk("idle_operands", {alu_operand1, alu_operand2}, 0);
      if (w >= 0) begin
        ins = req_instr[INSTR_W*w +: INSTR_W];
        m_opc = int'(ins[18:16]);
        m_op1 = int'(ins[15:8]);
        m_op2 = int'(ins[7:0]);
        m_id = w;
        m_last = w;
        m_pend = 1;
        m_age = 1;
        acc_flags[w] = 1'b1;
        acc_id_q.push_back(w);
        acc_cyc_q.push_back(cyc);
      end
    end else if (m_age == 1) begin
      chk("exec_req_ready", req_ready, 0);
      chk("exec_busy", busy, 1);
      chk("exec_rsp_valid", rsp_valid, 0);
      chk("exec_alu_select", alu_select, 1 << m_opc);
      chk("exec_operand1", alu_operand1, m_op1);
      chk("exec_operand2", alu_operand2, m_op2);
      sel_q.push_back(int'(alu_select));
      m_age = 2;
    end else begin
      chk("resp_rsp_valid", rsp_valid, 1);
      chk("resp_busy", busy, 1);
      chk("resp_req_ready", req_ready, 0);
      chk("resp_alu_select", alu_select, 0);
      chk("resp_rsp_id", rsp_id, m_id);
      chk("resp_rsp_result", rsp_result, (m_op1 + m_op2 + m_opc) % 256);
      if (rsp_ready) begin
        if (rsp_valid) begin
          rsp_id_q.push_back(int'(rsp_id));
          rsp_res_q.push_back(int'(rsp_result));
          rsp_cyc_q.push_back(cyc);
        end
        m_pend = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic clear_logs();
    acc_id_q.delete(); acc_cyc_q.delete(); rsp_id_q.delete();
    rsp_res_q.delete(); rsp_cyc_q.delete(); sel_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input int r, input logic [18:0] ins, input int exp_sel,
                        input int exp_res, input string tag);
    clear_logs();
    req_instr[INSTR_W*r +: INSTR_W] = ins;
    req_valid = NREQ'(1 << r);
    tick();
    req_valid = '0;
    repeat (3) tick();
    chk({tag, "_accepts"}, acc_id_q.size(), 1);
    chk({tag, "_acc_id"}, (acc_id_q.size() > 0) ? acc_id_q[0] : -1, r);
    chk({tag, "_sel"}, (sel_q.size() > 0) ? sel_q[0] : -1, exp_sel);
    chk({tag, "_rsps"}, rsp_res_q.size(), 1);
    chk({tag, "_result"}, (rsp_res_q.size() > 0) ? rsp_res_q[0] : -1, exp_res);
    chk({tag, "_id"}, (rsp_id_q.size() > 0) ? rsp_id_q[0] : -1, r);
    chk({tag, "_latency"},
        (rsp_cyc_q.size() > 0 && acc_cyc_q.size() > 0) ? rsp_cyc_q[0] - acc_cyc_q[0] : -1, 2);
  endtask

  initial begin
    rst_n = 1'b1; req_valid = '0; req_instr = '0; rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("por_busy", busy, 0);
    chk("por_rsp_valid", rsp_valid, 0);
    chk("por_rsp_id", rsp_id, 0);
    chk("por_rsp_result", rsp_result, 0);
    chk("por_alu", {alu_select, alu_operand1, alu_operand2}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    single(0, {3'd2, 8'h10, 8'h05}, 32'h04, 32'h17, "single");
    single(0, {3'd7, 8'hFF, 8'hFF}, 32'h80, 32'h05, "wrap");

    // Back-pressure: the response must sit untouched until the consumer is ready.
    clear_logs();
    rsp_ready = 1'b0;
    req_instr[INSTR_W*1 +: INSTR_W] = {3'd5, 8'h21, 8'h42};
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    repeat (6) tick();
    chk("bp_hold_valid", rsp_valid, 1);
    chk("bp_hold_result", rsp_result, 32'h68);
    chk("bp_hold_id", rsp_id, 1);
    rsp_ready = 1'b1;
    tick();
    chk("bp_idle_after", busy, 0);
    chk("bp_rsps", rsp_res_q.size(), 1);
    chk("bp_result", (rsp_res_q.size() > 0) ? rsp_res_q[0] : -1, 32'h68);

    // Reset while executing drops the instruction.
    clear_logs();
    req_instr[0 +: INSTR_W] = {3'd3, 8'h01, 8'h02};
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_alu", {alu_select, alu_operand1, alu_operand2}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp", {rsp_valid, rsp_result}, 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mid_rst_no_rsp", rsp_res_q.size(), 0);

    // Contention straight after reset: rotation must start at requester 0.
    clear_logs();
    req_instr = {{3'd7, 8'h00, 8'h00}, {3'd1, 8'h00, 8'h00}};
    req_valid = 2'b11;
    repeat (12) tick();
    req_valid = '0;
    repeat (4) tick();
    chk("rr_accepts", acc_id_q.size(), 4);
    chk("rr_rsps", rsp_res_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant", (acc_id_q.size() > i) ? acc_id_q[i] : -1, i % 2);
      chk("rr_result", (rsp_res_q.size() > i) ? rsp_res_q[i] : -1, (i % 2 == 0) ? 1 : 7);
      if (i > 0)
        chk("rr_interval", (acc_cyc_q.size() > i) ? acc_cyc_q[i] - acc_cyc_q[i-1] : -1, 3);
    end

    // Quiet bus.
    repeat (10) begin
      @(negedge clk);
      #1;
      chk("quiet", {busy, rsp_valid, alu_select}, 0);
    end

    // Random traffic with legal hold-until-accepted requesters.
    clear_logs();
    for (int n = 0; n < 600; n++) begin
      tick();
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            req_instr[INSTR_W*i +: INSTR_W] = 19'($urandom);
            req_valid[i] = 1'b1;
          end
        end else if (acc_flags[i]) begin
          if ($urandom_range(0, 1) == 1) req_valid[i] = 1'b0;
          else req_instr[INSTR_W*i +: INSTR_W] = 19'($urandom);
        end
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) tick();
    chk("rand_rsp_count", rsp_res_q.size(), acc_id_q.size());
    chk("rand_drained", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
